// File: rtl/cp0_except_pkg.sv
// Shared CP0 definitions: register numbers, STATUS/CAUSE bit positions,
// exception codes and the CP operation encoding used by the decoder.
package cp0_except_pkg;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;
   localparam int ST_UM  = 4;

   localparam int CA_BD     = 31;
   localparam int CA_TI     = 30;
   localparam int CA_IP2    = 10;
   localparam int CA_EXC_LO = 2;

   typedef enum logic [4:0] {
      EXC_INT = 5'd0,
      EXC_SYS = 5'd8,
      EXC_RI  = 5'd10,
      EXC_CPU = 5'd11
   } exc_code_t;

   typedef enum logic [1:0] {
      CP_NONE  = 2'b00,
      CP_STORE = 2'b01,
      CP_ERET  = 2'b10,
      CP_RSVD  = 2'b11
   } cp_oper_t;

   // A delay-slot instruction restarts at its branch, one word earlier.
   function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic ds);
      return ds ? pc - 32'd4 : pc;
   endfunction

endpackage

// File: rtl/cp0_except_if.sv
// Decoder/EXE-side bus into the CP0 unit: operation, register access,
// exception flags and the EXE instruction's PC context.
interface cp0_except_if;
   import cp0_except_pkg::*;

   logic        en;
   cp_oper_t    cp_oper;
   logic [4:0]  addr_r;
   logic [31:0] data_r;
   logic [4:0]  addr_w;
   logic [31:0] data_w;
   logic        syscall;
   logic        illegal;
   logic        unrecognized;
   logic [31:0] ex_pc;
   logic        ex_delay_slot;
   logic        exc_flush;

   modport master (
      output en, cp_oper, addr_r, addr_w, data_w, syscall, illegal,
             unrecognized, ex_pc, ex_delay_slot,
      input  data_r, exc_flush
   );

   modport slave (
      input  en, cp_oper, addr_r, addr_w, data_w, syscall, illegal,
             unrecognized, ex_pc, ex_delay_slot,
      output data_r, exc_flush
   );

endinterface

// File: rtl/cp0_timer.sv
// COUNT/COMPARE timer: free-running counter with a sticky match flag TI,
// cleared only by a COMPARE write.
module cp0_timer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              count_we,
   input  logic              compare_we,
   input  logic              ti_clr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] count,
   output logic [DATA_W-1:0] compare,
   output logic              ti
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         compare <= '1;
         ti      <= 1'b0;
      end else begin
         count <= count_we ? wdata : count + 1'b1;
         if (compare_we)
            compare <= wdata;
         // A clear in the same cycle as a match wins.
         if (ti_clr)
            ti <= 1'b0;
         else if (count == compare)
            ti <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_except.sv
// Coprocessor-0 and exception unit: prioritises exceptions, interrupts, ERET
// and MTC0, owns STATUS/CAUSE/EPC and issues a registered PC redirect.
module cp0_except
   import cp0_except_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
   input  logic         clk,
   input  logic         rst,
   cp0_except_if.slave  bus,
   input  logic         ir_req,
   output logic         user_mode,
   output logic         jump_en,
   output logic [31:0]  jump_addr
);

   logic        st_ie, st_exl, st_um;
   logic        ca_bd;
   logic [4:0]  ca_code;
   logic [31:0] epc;
   logic [31:0] count, compare;
   logic        ti;

   logic        accept, irq_take, exc_take, eret_take, mtc0_take;
   exc_code_t   exc_code;

   // Reset overrides anything presented in the same cycle.
   assign accept    = bus.en & ~rst;
   assign irq_take  = st_ie & ~st_exl & (ir_req | ti);
   assign exc_take  = accept & (bus.illegal | bus.unrecognized | bus.syscall | irq_take);
   assign eret_take = accept & ~exc_take & (bus.cp_oper == CP_ERET);
   assign mtc0_take = accept & ~exc_take & (bus.cp_oper == CP_STORE);

   assign bus.exc_flush = exc_take | eret_take;
   assign user_mode     = st_um & ~st_exl;

   always_comb begin
      exc_code = EXC_INT;
      if (bus.illegal)
         exc_code = EXC_CPU;
      else if (bus.unrecognized)
         exc_code = EXC_RI;
      else if (bus.syscall)
         exc_code = EXC_SYS;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_ie   <= 1'b0;
         st_exl  <= 1'b0;
         st_um   <= 1'b0;
         ca_bd   <= 1'b0;
         ca_code <= '0;
         epc     <= '0;
      end else if (exc_take) begin
         // Nested exceptions keep the original return point.
         if (!st_exl) begin
            epc   <= epc_of(bus.ex_pc, bus.ex_delay_slot);
            ca_bd <= bus.ex_delay_slot;
         end
         ca_code <= exc_code;
         st_exl  <= 1'b1;
      end else if (eret_take) begin
         st_exl <= 1'b0;
      end else if (mtc0_take) begin
         if (bus.addr_w == REG_STATUS) begin
            st_ie  <= bus.data_w[ST_IE];
            st_exl <= bus.data_w[ST_EXL];
            st_um  <= bus.data_w[ST_UM];
         end
         if (bus.addr_w == REG_EPC)
            epc <= bus.data_w;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         jump_en   <= 1'b0;
         jump_addr <= '0;
      end else begin
         jump_en <= exc_take | eret_take;
         if (exc_take)
            jump_addr <= EXC_VECTOR;
         else if (eret_take)
            jump_addr <= epc;
      end
   end

   cp0_timer #(.DATA_W(32)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (mtc0_take && bus.addr_w == REG_COUNT),
      .compare_we (mtc0_take && bus.addr_w == REG_COMPARE),
      .ti_clr     (mtc0_take && bus.addr_w == REG_COMPARE),
      .wdata      (bus.data_w),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_comb begin
      bus.data_r = '0;
      case (bus.addr_r)
         REG_COUNT:   bus.data_r = count;
         REG_COMPARE: bus.data_r = compare;
         REG_STATUS: begin
            bus.data_r[ST_IE]  = st_ie;
            bus.data_r[ST_EXL] = st_exl;
            bus.data_r[ST_UM]  = st_um;
         end
         REG_CAUSE: begin
            bus.data_r[CA_BD]                 = ca_bd;
            bus.data_r[CA_TI]                 = ti;
            bus.data_r[CA_IP2]                = ir_req;
            bus.data_r[CA_EXC_LO+4:CA_EXC_LO] = ca_code;
         end
         REG_EPC:     bus.data_r = epc;
         default:     bus.data_r = '0;
      endcase
   end

endmodule

// File: doc/cp0_except.md
# cp0_except

Coprocessor-0 and exception unit for the MIPS 5-stage pipelined CPU. It executes the CP0 operations and exception flags produced by the instruction decoder: MTC0/MFC0 register access, ERET, syscall, illegal (privileged-in-user) and unrecognized instructions, plus an external interrupt and an internal timer interrupt. It sits beside the EXE stage, owns STATUS/CAUSE/EPC/COUNT/COMPARE, drives `user_mode` back to the decoder, and issues a one-cycle PC redirect to the fetch stage.

## Interface

Parameters:
- EXC_VECTOR, 32'h0000_0180, PC loaded on any exception or interrupt.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  pipeline advance; events are accepted only when high
- cp_oper  in  2  CP operation: 00 none, 01 store (MTC0), 10 ERET, 11 reserved (treated as none)
- addr_r  in  5  CP0 read register number (MFC0 rd field)
- data_r  out  32  combinational read data of `addr_r`; 0 for unimplemented registers
- addr_w  in  5  CP0 write register number
- data_w  in  32  MTC0 write data (RT value)
- syscall  in  1  syscall flag from the decoder
- illegal  in  1  privileged instruction in user mode
- unrecognized  in  1  reserved instruction
- ir_req  in  1  external interrupt, level-sensitive
- ex_pc  in  32  PC of the instruction currently in EXE
- ex_delay_slot  in  1  EXE instruction is in a delay slot
- exc_flush  out  1  combinational; squash the EXE instruction and all younger instructions
- jump_en  out  1  registered PC redirect strobe
- jump_addr  out  32  registered redirect target
- user_mode  out  1  STATUS.UM & ~STATUS.EXL

## Operation

Registers:
- STATUS (12): bit0 IE, bit1 EXL, bit4 UM. Other bits read as 0.
- CAUSE (13): bit31 BD, bit30 TI, bit10 IP2 (mirrors `ir_req`), bits[6:2] ExcCode. Read-only to MTC0.
- EPC (14): R/W.
- COUNT (9): R/W. Increments every cycle regardless of `en`.
- COMPARE (11): R/W. A write clears TI.

Event selection, evaluated each cycle with `en=1`, highest priority first:
- illegal: ExcCode 11.
- unrecognized: ExcCode 10.
- syscall: ExcCode 8.
- interrupt: ExcCode 0. Taken when IE=1, EXL=0, and (`ir_req` | TI).
- ERET.
- MTC0.

Exception (any of the first four):
- If EXL=0: EPC <= `ex_delay_slot` ? `ex_pc`-4 : `ex_pc`; BD <= `ex_delay_slot`.
- If EXL=1: EPC and BD are unchanged.
- Always: ExcCode updated, EXL <= 1, `jump_addr` <= EXC_VECTOR, `jump_en` <= 1, `exc_flush`=1.
- A concurrent ERET or MTC0 is dropped.

ERET: EXL <= 0, `jump_addr` <= EPC, `jump_en` <= 1, `exc_flush`=1.

MTC0: writes the register at the same edge. Writes to read-only or unimplemented registers are ignored.

Timer:
- TI <= 1 when COUNT == COMPARE (after increment comparison on the current value).
- A COMPARE write clears TI at that edge; the write takes priority over setting TI.
- An MTC0 to COUNT overrides the increment.

`en=0`: no event is accepted, `exc_flush`=0, and `jump_en` <= 0. COUNT and TI still update.

## Timing

- Reset values: STATUS=0 (kernel mode, IE=0, EXL=0), CAUSE=0, EPC=0, COUNT=0, COMPARE=32'hFFFF_FFFF, `jump_en`=0, `jump_addr`=0. Consequently `user_mode`=0.
- `data_r` is combinational. A read of a register written at edge N returns the new value from cycle N+1; there is no write-to-read bypass.
- Event at edge N: `exc_flush` is high during cycle N (before the edge). `jump_en` is high for exactly cycle N+1. Register updates are visible from N+1.
- `jump_en` is always a single-cycle pulse. Back-to-back events on consecutive cycles produce consecutive pulses with the newer target.
- `user_mode` changes the cycle after an exception or ERET edge.
- Reset asserted mid-operation overrides all events in that cycle. `jump_en` is 0 on the following cycle.
- COUNT wraps from 32'hFFFF_FFFF to 0.

## Structure

- The shared package holds:
  - CP0 register numbers (9, 11, 12, 13, 14).
  - STATUS/CAUSE bit positions.
  - ExcCode constants (0, 8, 10, 11).
  - `cp_oper` encodings (shared with the decoder's CP operation codes).
- One sub-module, `cp0_timer`, contains COUNT, COMPARE, and TI generation, with write ports and a `ti_clr` input.
- Priority selection and the STATUS/CAUSE/EPC registers stay in the top level.

## Test plan

- Reset, then MTC0 STATUS=32'h11 at `en=1` → next cycle `data_r`(12)=32'h11 and `user_mode`=1.
- `illegal`=1 with `ex_pc`=32'h400, `ex_delay_slot`=1, EXL=0 → `exc_flush`=1 that cycle; next cycle `jump_en`=1, `jump_addr`=32'h180, EPC=32'h3FC, BD=1, ExcCode=11, `user_mode`=0.
- `syscall` and `unrecognized` together with ERET → ExcCode=10, redirect to 32'h180, EXL stays 1, ERET ignored.
- ERET with EPC=32'h1000 → `jump_en` pulse for one cycle with `jump_addr`=32'h1000, EXL=0.
- COMPARE=5, IE=1, EXL=0, `en`=1 → TI sets when COUNT reaches 5; interrupt taken with ExcCode=0. Writing COMPARE clears TI. With EXL=1, `ir_req`=1 causes no redirect.
- Assert `rst` in the same cycle as `syscall` → no `jump_en` afterwards, all registers at reset values.
